// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// The counter increment is a ripple of half-adders so no '+' appears in the datapath.
package serial_adder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_e;

  localparam int unsigned SaMaxWidth = 32;
  localparam int unsigned SaMaxCntW  = $clog2(SaMaxWidth);

  function automatic logic [SaMaxCntW-1:0] sa_incr(input logic [SaMaxCntW-1:0] v);
    logic [SaMaxCntW-1:0] r;
    logic                 c;
    c = 1'b1;
    for (int i = 0; i < SaMaxCntW; i++) begin
      r[i] = v[i] ^ c;
      c    = c & v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand and result valid/ready channels of the serial adder.
// master drives operands and consumes results; slave is the adder itself.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );

endinterface

// File: rtl/full_adder.sv
// Single-bit full adder cell; the only arithmetic element of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  logic half;

  assign half  = a ^ b;
  assign sum   = half ^ cin;
  assign carry = (a & b) | (cin & half);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, LSB first, result shifted in from the MSB.
// Accepts an operand word in IDLE, runs WIDTH cycles, then holds the result in DONE.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  sa_state_e        state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [CntW-1:0]  cnt_inc;
  logic             last_bit;
  logic             fa_sum;
  logic             fa_carry;

  full_adder u_full_adder (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .carry(fa_carry)
  );

  assign cnt_inc  = CntW'(sa_incr(SaMaxCntW'(cnt_q)));
  assign last_bit = (cnt_q == CntW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
  end

  assign bus.sum  = res_q;
  assign bus.cout = cout_q;

  always_comb begin
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        carry_d = fa_carry;
        cnt_d   = cnt_inc;
        if (last_bit) cout_d = fa_carry;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed operands push expected results,
// a monitor pops and compares on every output handshake.
module tb_serial_adder;

  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    time          t_hs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_in     = 0;
  int   n_out    = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one operand word until accepted; keep leaves in_valid high afterwards.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                      input logic [W-1:0] es, input logic ec, input bit keep);
    logic hs;
    bit   done;
    exp_t e;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = c;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      hs = bus.in_ready;
      @(posedge clk);
      if (hs) begin
        done   = 1'b1;
        e.sum  = es;
        e.cout = ec;
        e.t_hs = $time;
        sb.push_back(e);
        n_in++;
      end
    end
    #1;
    if (!keep) bus.in_valid = 1'b0;
    check("send_accept", 64'(done), 64'd1);
  endtask

  task automatic drain(input int max_cyc);
    for (int i = 0; i < max_cyc && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: latency on first valid cycle, value compare on handshake.
  initial begin
    bit seen;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 1'b0;
      end else if (bus.out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 64'(bus.out_valid), 64'd0);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            check("latency", 64'($time - sb[0].t_hs), 64'(W * 10 + 5));
          end
          if (bus.out_ready) begin
            check("sum", 64'(bus.sum), 64'(sb[0].sum));
            check("cout", 64'(bus.cout), 64'(sb[0].cout));
            void'(sb.pop_front());
            n_out++;
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_sum", 64'(bus.sum), 64'd0);
    check("rst_cout", 64'(bus.cout), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    send(8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b0);
    drain(50);
    send(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    drain(50);
    send(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    drain(50);
    send(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    drain(50);

    // Backpressure: result must hold while out_ready is low.
    bus.out_ready = 1'b0;
    send(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
    for (int i = 0; i < 50 && !bus.out_valid; i++) @(negedge clk);
    check("bp_valid", 64'(bus.out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_sum_hold", 64'(bus.sum), 64'h30);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_valid_hold", 64'(bus.out_valid), 64'd1);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    drain(10);

    // Reset three edges into RUN aborts the operation.
    send(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    n_in--;
    #1;
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_sum", 64'(bus.sum), 64'd0);
    check("abort_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
    drain(50);

    // in_valid held high across four operands.
    send(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b1);
    send(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    send(8'h7F, 8'h01, 1'b1, 8'h81, 1'b0, 1'b1);
    send(8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0);
    drain(100);

    check("in_out_count", 64'(n_out), 64'(n_in));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
